mult_div_unit: RTL and testbench
================================

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 The block SHALL have one clock and one reset; the reset is asynchronous and active-low.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 reset  in  1  asynchronous active-low reset.
REQ-004 mult_start  in  1  one-cycle request from the control unit (MultCtrl) to start a signed multiply.
REQ-005 div_start  in  1  one-cycle request from the control unit (DivCtrl) to start a signed divide.
REQ-006 op_a  in  32  multiplicand or dividend (rs), two's complement.
REQ-007 op_b  in  32  multiplier or divisor (rt), two's complement.
REQ-008 hi  out  32  HI register: product[63:32] or remainder.
REQ-009 lo  out  32  LO register: product[31:0] or quotient.
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 done  out  1  one-cycle pulse when hi and lo have just been updated.
REQ-012 div_zero  out  1  one-cycle divide-by-zero exception pulse to the control unit.

Function
REQ-013 The FSM SHALL have the states IDLE, MUL_RUN, DIV_RUN, SIGN_FIX and DONE.
REQ-014 In IDLE, a sampled mult_start SHALL capture op_a and op_b, load the iteration counter with 32 and go to MUL_RUN.
REQ-015 In IDLE, a sampled div_start SHALL capture the operands and go to DIV_RUN.
REQ-016 If mult_start and div_start are high together, the multiply SHALL win and the divide SHALL be dropped.
REQ-017 Starts sampled outside IDLE SHALL be ignored, with no queueing and no effect on the operation in flight.
REQ-018 MUL_RUN SHALL perform one radix-2 Booth add/shift step on a 65-bit accumulator per cycle, for exactly 32 cycles.
REQ-019 DIV_RUN SHALL perform one restoring shift/subtract step per cycle on the operand magnitudes, for exactly 32 cycles.
REQ-020 After the 32nd step, both run states SHALL go to SIGN_FIX.
REQ-021 SIGN_FIX SHALL apply the divide signs: quotient negated when op_a and op_b signs differ; remainder carries op_a's sign; multiply passes through unchanged.
REQ-022 On entry to DONE, hi and lo SHALL be updated and done SHALL be 1 for that single cycle; the next state SHALL be IDLE.
REQ-023 Latency SHALL be exactly 34 cycles: start sampled at edge 0, results visible and done=1 after edge 34.
REQ-024 The captured 64-bit product SHALL be exact for all inputs; 0x80000000*0x80000000 SHALL give hi=0x40000000, lo=0x00000000.
REQ-025 Divide SHALL truncate toward zero; 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0x00000000, with no exception.
REQ-026 hi and lo SHALL hold their previous values throughout every operation until DONE.
REQ-027 A back-to-back start SHALL be accepted in the IDLE cycle immediately following DONE.

Reset
REQ-028 Reset assertion SHALL immediately force IDLE and clear hi, lo, busy, done, div_zero, the counter and the internal operand registers to 0.
REQ-029 Reset during an operation SHALL abort it with no done pulse; the next start after release SHALL behave as from power-up.

Configuration
REQ-030 Macro MULT_DIV_DIVZERO_EXC_EN defined: div_start with op_b==0 SHALL go IDLE->DONE-less abort, pulse div_zero for one cycle (the cycle after the start edge), leave hi/lo unchanged, assert no done, and return to IDLE after one busy cycle.
REQ-031 Macro undefined: div_zero SHALL be tied 0; a divide by zero SHALL run the full 34 cycles and produce hi=op_a, lo=0xFFFFFFFF, with done pulsed.

Verification
REQ-032 mult_start, op_a=7, op_b=0xFFFFFFFD -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB, done=1 for one cycle, busy=1 throughout.
REQ-033 div_start, op_a=0xFFFFFFF9 (-7), op_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 Both starts together, op_a=3, op_b=5 -> multiply result hi=0, lo=15; a second div_start pulsed at cycle 10 is ignored and a single done is seen.
REQ-035 div_start, op_b=0 -> with the macro: div_zero pulse, hi/lo unchanged, no done; without the macro: hi=op_a, lo=0xFFFFFFFF after 34 cycles.
REQ-036 Reset asserted at cycle 15 of a multiply -> hi=lo=0 and busy=0 immediately, no done; a subsequent 2*3 gives lo=6.

Source files
------------

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/operand/result signal bundle for mult_div_unit
interface mult_div_unit_if;
    logic        mult_start;
    logic        div_start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    modport master (
        output mult_start, div_start, op_a, op_b,
        input  hi, lo, busy, done, div_zero
    );

    modport slave (
        input  mult_start, div_start, op_a, op_b,
        output hi, lo, busy, done, div_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed Booth multiplier / restoring divider (optional MULT_DIV_DIVZERO_EXC_EN)
module mult_div_unit (
    input  logic            clk,
    input  logic            rst_n,
    mult_div_unit_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        MUL_RUN  = 3'd1,
        DIV_RUN  = 3'd2,
        SIGN_FIX = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Multiply: {A[31:0], Q[31:0], q_-1}. Divide: {rem[32:0], dividend/quotient[31:0]}.
    // After SIGN_FIX both hold {hi, lo, 1'b0}.
    logic [64:0] acc_q, acc_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        is_div_q, is_div_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        abort;

    logic [31:0] a_in_mag;
    logic [31:0] b_mag;
    logic [32:0] booth_a;
    logic [32:0] booth_m;
    logic [32:0] booth_sum;
    logic [64:0] booth_next;
    logic [32:0] div_trial;
    logic        div_ge;
    logic [32:0] div_rem;
    logic [64:0] div_next;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

`ifdef MULT_DIV_DIVZERO_EXC_EN
    logic dz_q, dz_d;
    // A zero-divisor divide reaches DONE only through the exception path, so DONE must not commit it.
    assign abort        = is_div_q && (b_q == 32'd0);
    assign bus.div_zero = dz_q;
`else
    assign abort        = 1'b0;
    assign bus.div_zero = 1'b0;
`endif

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

    assign a_in_mag = bus.op_a[31] ? (~bus.op_a + 32'd1) : bus.op_a;
    assign b_mag    = b_q[31] ? (~b_q + 32'd1) : b_q;

    // Booth step: the add is done one bit wider so that subtracting 0x80000000 cannot overflow before the shift.
    assign booth_a = {acc_q[64], acc_q[64:33]};
    assign booth_m = {a_q[31], a_q};
    always_comb begin
        booth_sum = booth_a;
        case (acc_q[1:0])
            2'b01:   booth_sum = booth_a + booth_m;
            2'b10:   booth_sum = booth_a - booth_m;
            default: booth_sum = booth_a;
        endcase
    end
    assign booth_next = {booth_sum, acc_q[32:1]};

    // Restoring step: shift the next dividend bit into the partial remainder and subtract if it fits.
    assign div_trial = {acc_q[63:32], acc_q[31]};
    assign div_ge    = (div_trial >= {1'b0, b_mag});
    assign div_rem   = div_ge ? (div_trial - {1'b0, b_mag}) : div_trial;
    assign div_next  = {div_rem, acc_q[30:0], div_ge};

    // Sign restoration; a zero divisor keeps the all-ones quotient and the original dividend as remainder.
    assign q_fix = ((a_q[31] ^ b_q[31]) && (b_q != 32'd0)) ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
    assign r_fix = a_q[31] ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

    // Next-state and datapath update for the whole controller.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        a_d      = a_q;
        b_d      = b_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
`ifdef MULT_DIV_DIVZERO_EXC_EN
        dz_d     = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (bus.mult_start) begin
                    a_d      = bus.op_a;
                    b_d      = bus.op_b;
                    is_div_d = 1'b0;
                    cnt_d    = 6'd32;
                    acc_d    = {32'd0, bus.op_b, 1'b0};
                    state_d  = MUL_RUN;
                end else if (bus.div_start) begin
                    a_d      = bus.op_a;
                    b_d      = bus.op_b;
                    is_div_d = 1'b1;
                    cnt_d    = 6'd32;
                    acc_d    = {33'd0, a_in_mag};
`ifdef MULT_DIV_DIVZERO_EXC_EN
                    if (bus.op_b == 32'd0) begin
                        state_d = DONE;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = DIV_RUN;
                    end
`else
                    state_d  = DIV_RUN;
`endif
                end
            end
            MUL_RUN: begin
                acc_d = booth_next;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = SIGN_FIX;
                end
            end
            DIV_RUN: begin
                acc_d = div_next;
                cnt_d = cnt_q - 6'd1;
                if (cnt_q == 6'd1) begin
                    state_d = SIGN_FIX;
                end
            end
            SIGN_FIX: begin
                if (is_div_q) begin
                    acc_d = {r_fix, q_fix, 1'b0};
                end
                state_d = DONE;
            end
            DONE: begin
                if (!abort) begin
                    hi_d   = acc_q[64:33];
                    lo_d   = acc_q[32:1];
                    done_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            acc_q    <= 65'd0;
            a_q      <= 32'd0;
            b_q      <= 32'd0;
            is_div_q <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef MULT_DIV_DIVZERO_EXC_EN
    // Divide-by-zero exception pulse register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dz_q <= 1'b0;
        end else begin
            dz_q <= dz_d;
        end
    end
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit with random stimulus and reference model
module tb_mult_div_unit;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mult_div_unit_if ifc ();

    mult_div_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

`ifdef MULT_DIV_DIVZERO_EXC_EN
    localparam bit DZ_EN = 1'b1;
`else
    localparam bit DZ_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: plain signed arithmetic, truncating division, fixed results for the two special divides.
    function automatic exp_t model(input bit is_mul, input logic [31:0] a, input logic [31:0] b);
        exp_t   r;
        longint p;
        int     q;
        int     m;
        r.due = 0;
        if (is_mul) begin
            p    = longint'(int'(a)) * longint'(int'(b));
            r.hi = p[63:32];
            r.lo = p[31:0];
        end else if (b == 32'd0) begin
            r.hi = a;
            r.lo = 32'hFFFF_FFFF;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r.hi = 32'h0;
            r.lo = 32'h8000_0000;
        end else begin
            q    = int'(a) / int'(b);
            m    = int'(a) % int'(b);
            r.hi = m;
            r.lo = q;
        end
        return r;
    endfunction

    // Monitor: every done pulse pops one expected result and checks value and latency.
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1) begin
            if (prev_done) check("done_one_cycle", 64'(ifc.done), 64'h0);
            if (ifc.done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'h1, 64'h0);
                end else begin
                    e = sb.pop_front();
                    check("hi", 64'(ifc.hi), 64'(e.hi));
                    check("lo", 64'(ifc.lo), 64'(e.lo));
                    check("latency", 64'(cyc), 64'(e.due));
                end
            end
            prev_done = (ifc.done === 1'b1);
        end else begin
            prev_done = 1'b0;
        end
    end

    // Issue one operation at a negedge and return at the negedge where done shows (or abort/reset ends it).
    task automatic run_op(input bit do_mul, input bit do_div, input logic [31:0] a, input logic [31:0] b,
                          input int rst_at, input int extra_at);
        exp_t        e;
        logic [31:0] hi0;
        logic [31:0] lo0;
        bit          abort;
        bit          ok;
        abort = !do_mul && do_div && (b == 32'd0) && DZ_EN;
        hi0 = ifc.hi;
        lo0 = ifc.lo;
        ifc.mult_start = do_mul;
        ifc.div_start  = do_div;
        ifc.op_a       = a;
        ifc.op_b       = b;
        if (!abort && rst_at < 0) begin
            e     = model(do_mul, a, b);
            e.due = cyc + 35;
            sb.push_back(e);
        end
        @(negedge clk);
        ifc.mult_start = 1'b0;
        ifc.div_start  = 1'b0;
        ifc.op_a       = $urandom;
        ifc.op_b       = $urandom;
        if (abort) begin
            check("dz_pulse", 64'({ifc.div_zero, ifc.busy, ifc.done}), 64'h6);
            @(negedge clk);
            check("dz_after", 64'({ifc.div_zero, ifc.busy, ifc.done}), 64'h0);
            check("dz_hold", {ifc.hi, ifc.lo}, {hi0, lo0});
            return;
        end
        ok = 1'b1;
        for (int i = 1; i <= 40 && ifc.done !== 1'b1; i++) begin
            if (ifc.busy !== 1'b1 || ifc.div_zero !== 1'b0 || ifc.hi !== hi0 || ifc.lo !== lo0) ok = 1'b0;
            ifc.div_start = (i == extra_at);
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_hilo", {ifc.hi, ifc.lo}, 64'h0);
                check("rst_flags", 64'({ifc.busy, ifc.done, ifc.div_zero}), 64'h0);
                @(negedge clk);
                check("rst_no_done", 64'(ifc.done), 64'h0);
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
        end
        ifc.div_start = 1'b0;
        check("busy_hold", 64'(ok), 64'h1);
        check("done_seen", 64'(ifc.done === 1'b1), 64'h1);
    endtask

    function automatic logic [31:0] pick();
        logic [31:0] corners [6];
        corners[0] = 32'h0;
        corners[1] = 32'h1;
        corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000;
        corners[4] = 32'h7FFF_FFFF;
        corners[5] = 32'h2;
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 5)];
        return $urandom;
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n          = 1'b1;
        ifc.mult_start = 1'b0;
        ifc.div_start  = 1'b0;
        ifc.op_a       = 32'h0;
        ifc.op_b       = 32'h0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_hilo", {ifc.hi, ifc.lo}, 64'h0);
        check("reset_flags", 64'({ifc.busy, ifc.done, ifc.div_zero}), 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, -1);
        check("mul_7_m3", {ifc.hi, ifc.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, -1);
        check("div_m7_2", {ifc.hi, ifc.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(1'b1, 1'b1, 32'd3, 32'd5, -1, 10);
        check("both_3_5", {ifc.hi, ifc.lo}, 64'h0000_0000_0000_000F);
        run_op(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, -1);
        check("mul_min_min", {ifc.hi, ifc.lo}, 64'h4000_0000_0000_0000);
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        check("div_min_m1", {ifc.hi, ifc.lo}, 64'h0000_0000_8000_0000);
        run_op(1'b0, 1'b1, 32'h1234_5678, 32'd0, -1, -1);
        run_op(1'b0, 1'b1, 32'h8765_4321, 32'd0, -1, -1);
        if (!DZ_EN) check("div_by_zero", {ifc.hi, ifc.lo}, 64'h8765_4321_FFFF_FFFF);

        run_op(1'b1, 1'b0, 32'h0001_2345, 32'h0000_0777, 15, -1);
        @(negedge clk);
        run_op(1'b1, 1'b0, 32'd2, 32'd3, -1, -1);
        check("mul_after_rst", {ifc.hi, ifc.lo}, 64'h0000_0000_0000_0006);

        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 2);
            run_op(kind != 1, kind != 0, pick(), pick(), -1,
                   ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 33)) : -1);
        end

        repeat (50) @(negedge clk);
        check("sb_empty", 64'(sb.size()), 64'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
